// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR controller: one shared MAC stepped over N+1 taps per sample.
// Define FIR_SEQ_SHADOW_EN for a shadow coefficient bank with a cfg_commit port.
module fir_seq_ctrl #(
  parameter  int N   = 5,
  parameter  int W_X = 8,
  parameter  int W_K = 8,
  localparam int W_A = $clog2(N+1),
  localparam int W_Y = W_X + W_K + $clog2(N+1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [W_X-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [W_Y-1:0] m_data,
  input  logic                  cfg_we,
  input  logic [W_A-1:0]        cfg_addr,
  input  logic signed [W_K-1:0] cfg_data,
`ifdef FIR_SEQ_SHADOW_EN
  input  logic                  cfg_commit,
`endif
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [W_A-1:0] LAST = W_A'(N);

  logic [1:0]                state;
  logic signed [W_K-1:0]     k  [0:N];
  logic signed [W_X-1:0]     dl [0:N];
  logic [W_A-1:0]            head, head_nxt, idx, tap_ptr;
  logic signed [W_Y-1:0]     acc, acc_nxt;
  logic signed [W_X+W_K-1:0] prod;
  logic                      accept, cfg_hit;

  assign s_ready = (state == S_IDLE);
  assign busy    = (state == S_MAC) || (state == S_OUT);
  assign accept  = s_valid && s_ready;
  assign cfg_hit = cfg_we && (cfg_addr <= LAST);

  always_comb begin
    head_nxt = (head == LAST) ? '0 : head + 1'b1;
    // (head - idx) mod (N+1) without a divider
    if (head >= idx) tap_ptr = head - idx;
    else             tap_ptr = head + W_A'(N+1) - idx;
    prod    = k[idx] * dl[tap_ptr];
    acc_nxt = acc + W_Y'(prod);
  end

`ifdef FIR_SEQ_SHADOW_EN
  logic signed [W_K-1:0] sh [0:N];
  logic                  commit_pend, commit_go;

  assign commit_go = (cfg_commit || commit_pend) && (state == S_IDLE) && !accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N+1; i++) begin
        sh[i] <= '0;
        k[i]  <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      if (cfg_hit) sh[cfg_addr] <= cfg_data;
      if (commit_go) begin
        for (int unsigned i = 0; i < N+1; i++) k[i] <= sh[i];
        commit_pend <= 1'b0;
      end else if (cfg_commit) begin
        commit_pend <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N+1; i++) k[i] <= '0;
    end else if (cfg_hit && state == S_IDLE) begin
      k[cfg_addr] <= cfg_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      head    <= '0;
      idx     <= '0;
      acc     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      for (int unsigned i = 0; i < N+1; i++) dl[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            head         <= head_nxt;
            dl[head_nxt] <= s_data;
            acc          <= '0;
            idx          <= '0;
            state        <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            m_data  <= acc_nxt;
            m_valid <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl (default build): directed and random samples
// checked against a queue-based convolution model.
module tb_fir_seq_ctrl;
  localparam int N   = 5;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int W_A = $clog2(N+1);
  localparam int W_Y = W_X + W_K + $clog2(N+1);

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  s_valid, s_ready, m_valid, m_ready, cfg_we, busy;
  logic signed [W_X-1:0] s_data;
  logic signed [W_Y-1:0] m_data;
  logic [W_A-1:0]        cfg_addr;
  logic signed [W_K-1:0] cfg_data;

  fir_seq_ctrl #(.N(N), .W_X(W_X), .W_K(W_K)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int kref [N+1];
  int hist [$];   // newest sample at index 0

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_out();
    int s = 0;
    for (int i = 0; i <= N; i++)
      if (i < hist.size()) s += kref[i] * hist[i];
    return s;
  endfunction

  task automatic push_sample(input int x);
    hist.push_front(x);
    if (hist.size() > N+1) hist.delete(hist.size()-1);
  endtask

  task automatic model_clear();
    for (int i = 0; i <= N; i++) kref[i] = 0;
    hist.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b0;
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  // Only called while the controller is idle, so in-range writes land.
  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = W_A'(addr); cfg_data = W_K'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr <= N) kref[addr] = data;
  endtask

  task automatic load_ramp();
    for (int i = 0; i <= N; i++) cfg_write(i, i + 1);
  endtask

  // cw_mode: 0 none, 1 write coincident with accept, 2 write during MAC
  task automatic send_sample(input int x, input int hold, input int cw_mode,
                             input int cw_addr, input int cw_data, output int got);
    int edges, exp;
    logic signed [W_Y-1:0] held;
    @(negedge clk);
    s_valid = 1'b1; s_data = W_X'(x); m_ready = 1'b0;
    if (cw_mode == 1) begin
      cfg_we = 1'b1; cfg_addr = W_A'(cw_addr); cfg_data = W_K'(cw_data);
    end
    chk("s_ready_idle", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; cfg_we = 1'b0;
    if (cw_mode == 1 && cw_addr <= N) kref[cw_addr] = cw_data;
    push_sample(x);
    exp = model_out();
    chk("busy_mac", busy, 1);
    chk("s_ready_mac", s_ready, 0);
    edges = 1;  // the accept edge counts as the first
    if (cw_mode == 2) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = W_A'(cw_addr); cfg_data = W_K'(cw_data);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      edges++;
    end
    while (m_valid !== 1'b1 && edges < 4*N + 8) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, N + 2);
    chk("m_data", m_data, exp);
    got = int'(m_data);
    held = m_data;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, held);
      chk("hold_s_ready", s_ready, 0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("ack_m_valid", m_valid, 0);
    chk("ack_s_ready", s_ready, 1);
  endtask

  task automatic throughput();
    int cyc = 0, outs = 0;
    int acc_cyc [$];
    int val_cyc [$];
    int expq [$];
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'sd5; m_ready = 1'b1;
    while (outs < 6 && cyc < 200) begin
      if (s_ready === 1'b1 && s_valid) begin
        acc_cyc.push_back(cyc);
        push_sample(5);
        expq.push_back(model_out());
      end
      if (m_valid === 1'b1) begin
        val_cyc.push_back(cyc);
        chk("tp_data", m_data, (expq.size() > 0) ? expq.pop_front() : -1);
        outs++;
        if (outs == 6) s_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("tp_outputs", outs, 6);
    chk("tp_accepts", acc_cyc.size(), 6);
    if (acc_cyc.size() > 0 && val_cyc.size() > 0)
      chk("tp_first_latency", val_cyc[0] - acc_cyc[0], N + 2);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("tp_interval", acc_cyc[i] - acc_cyc[i-1], N + 3);
  endtask

  task automatic reset_mid_mac(input int x);
    @(negedge clk);
    s_valid = 1'b1; s_data = W_X'(x);
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
  endtask

  initial begin
    int got;
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // impulse response
    load_ramp();
    send_sample(1, 0, 0, 0, 0, got);
    chk("impulse", got, 1);
    for (int i = 1; i <= N; i++) begin
      send_sample(0, 0, 0, 0, 0, got);
      chk("impulse", got, i + 1);
    end

    // signed extremes
    do_reset();
    for (int i = 0; i <= N; i++) cfg_write(i, -1);
    for (int i = 0; i <= N; i++) begin
      send_sample(-128, 0, 0, 0, 0, got);
      chk("extreme", got, 128 * (i + 1));
    end

    // back-to-back with m_ready held high
    do_reset();
    load_ramp();
    throughput();

    // backpressure then immediate follow-up sample
    send_sample(3, 10, 0, 0, 0, got);
    send_sample(-7, 0, 0, 0, 0, got);

    // coefficient write gating
    send_sample(4, 0, 2, 0, 7, got);
    send_sample(2, 0, 1, 0, 7, got);
    cfg_write(6, 9);
    send_sample(1, 0, 0, 0, 0, got);

    // reset mid-MAC clears coefficients and history
    reset_mid_mac(9);
    send_sample(7, 0, 0, 0, 0, got);
    chk("post_reset_k_zero", got, 0);
    reset_mid_mac(9);
    load_ramp();
    send_sample(2, 0, 0, 0, 0, got);
    chk("post_reset_two", got, 2);

    // random coefficients, samples and backpressure
    for (int r = 0; r < 16; r++) begin
      if (r % 4 == 0)
        for (int i = 0; i <= N; i++) cfg_write(i, $signed(W_K'($urandom)));
      send_sample($signed(W_X'($urandom)), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 7),
                  $signed(W_K'($urandom)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
